// File: rtl/nibble_pkg.sv
// Shared types and the bit-order mapping helper for the nibble deserializer.
package nibble_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] bit_cnt_t;

  localparam int BITS_PER_NIBBLE = 4;
  localparam bit_cnt_t LAST_BIT = bit_cnt_t'(BITS_PER_NIBBLE - 1);

  // arrival[3] is the earliest received bit; result[3] drives a, result[0] drives d.
  function automatic nibble_t map_nibble(input nibble_t arrival, input logic msb_first);
    if (msb_first)
      return arrival;
    else
      return {arrival[0], arrival[1], arrival[2], arrival[3]};
  endfunction

endpackage

// File: rtl/nibble_out_reg.sv
// Output holding register: presents one nibble under a valid/ready handshake,
// allowing a new nibble to load in the same cycle the current one is taken.
module nibble_out_reg
  import nibble_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  nibble_t load_nib,
  input  logic    out_ready,
  output nibble_t nib_p1,
  output logic    vld_p1
);

  // Load only happens when empty or being emptied, so load wins over unload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (load) begin
      nib_p1 <= load_nib;
      vld_p1 <= 1'b1;
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: rtl/nibble_deser.sv
// Serial-to-parallel front stage: assembles a 1-bit stream into nibbles on a..d
// with valid/ready handshakes on both sides and a wrapping delivered-nibble count.
module nibble_deser
  import nibble_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] nib_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  bit_cnt_t   bit_cnt_p0;
  logic [2:0] partial_p0;
  logic       bit_xfer;
  logic       load;
  nibble_t    load_nib;
  nibble_t    nib_p1;
  logic       vld_p1;

  // The fourth bit needs room in the output register; flush always drains the input.
  assign din_ready = flush || !((bit_cnt_p0 == LAST_BIT) && vld_p1 && !out_ready);
  assign bit_xfer  = din_valid && din_ready;
  assign load      = bit_xfer && !flush && (bit_cnt_p0 == LAST_BIT);
  assign load_nib  = map_nibble({partial_p0, din}, MSB_FIRST != 0);

  // Stage p0: bit counter and partial shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_p0 <= '0;
      partial_p0 <= '0;
    end else if (flush) begin
      bit_cnt_p0 <= '0;
      partial_p0 <= '0;
    end else if (bit_xfer) begin
      bit_cnt_p0 <= bit_cnt_p0 + 2'd1;
      partial_p0 <= {partial_p0[1:0], din};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      nib_count <= '0;
    else if (load)
      nib_count <= nib_count + CNT_ONE;
  end

  // Stage p1: output holding register
  nibble_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_nib  (load_nib),
    .out_ready (out_ready),
    .nib_p1    (nib_p1),
    .vld_p1    (vld_p1)
  );

  assign {a, b, c, d} = nib_p1;
  assign out_valid    = vld_p1;

endmodule
